// File: rtl/data_mem_arbiter.sv
// Arbiter for the memory data-segment port: CPU load/store unit vs host I/O loader.
// Owns the start-I/O flag register at IO_ADDR and the 1-cycle registered read path.
module data_mem_arbiter #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned IO_ADDR      = 204,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wd,
   output logic             cpu_gnt,
   output logic             cpu_rvalid,
   output logic [WIDTH-1:0] cpu_rd,
   input  logic             io_req,
   input  logic             io_we,
   input  logic [WIDTH-1:0] io_addr,
   input  logic [WIDTH-1:0] io_wd,
   input  logic             io_burst,
   output logic             io_gnt,
   output logic             io_rvalid,
   output logic [WIDTH-1:0] io_rd,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd,
   output logic             start_io
);

   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0]    BURST_TOP  = BW'(BURST_MAX);
   localparam logic [WIDTH-1:0] FLAG_ADDR  = WIDTH'(IO_ADDR);

   typedef enum logic {
      IDLE,
      IO_BURST
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic             start_io_q, start_io_d;
   logic             cpu_rvalid_q, cpu_rvalid_d;
   logic             io_rvalid_q, io_rvalid_d;
   logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d;
   logic [WIDTH-1:0] io_rd_q, io_rd_d;

   logic             burst_hold;
   logic             cpu_win, io_win, any_win;
   logic             win_we;
   logic [WIDTH-1:0] win_addr, win_wd;
   logic             hit_flag;
   logic [WIDTH-1:0] rdata;
   logic [BW-1:0]    burst_inc;

   // Grant and memory-port steering
   always_comb begin
      burst_hold = (state_q == IO_BURST) && io_req && io_burst;
      io_win     = io_req && (burst_hold || !cpu_req || (starve_q == STARVE_TOP));
      cpu_win    = cpu_req && !io_win;
      any_win    = cpu_win || io_win;
      win_we     = 1'b0;
      win_addr   = '0;
      win_wd     = '0;
      if (io_win) begin
         win_we   = io_we;
         win_addr = io_addr;
         win_wd   = io_wd;
      end else if (cpu_win) begin
         win_we   = cpu_we;
         win_addr = cpu_addr;
         win_wd   = cpu_wd;
      end
      hit_flag = any_win && (win_addr == FLAG_ADDR);
      rdata    = hit_flag ? {{(WIDTH-1){1'b0}}, start_io_q} : mem_rd;
   end

   // Next-state logic for FSM, counters, flag and read path
   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      burst_inc = burst_q + 1'b1;

      starve_d = '0;
      if (io_req && !io_win) begin
         starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
      end

      start_io_d = start_io_q;
      if (any_win && win_we && hit_flag) begin
         start_io_d = win_wd[0];
      end

      cpu_rvalid_d = cpu_win && !cpu_we;
      io_rvalid_d  = io_win && !io_we;
      cpu_rd_d     = cpu_rvalid_d ? rdata : cpu_rd_q;
      io_rd_d      = io_rvalid_d ? rdata : io_rd_q;

      case (state_q)
         IDLE: begin
            // The entering grant is burst grant number one; BURST_MAX==1 never enters
            if (io_win && io_burst && (BURST_MAX > 1)) begin
               state_d = IO_BURST;
               burst_d = BW'(1);
            end
         end
         IO_BURST: begin
            if (!burst_hold) begin
               state_d = IDLE;
               burst_d = '0;
            end else if (burst_inc == BURST_TOP) begin
               state_d = IDLE;
               burst_d = '0;
            end else begin
               burst_d = burst_inc;
            end
         end
         default: begin
            state_d = IDLE;
            burst_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_q     <= '0;
         burst_q      <= '0;
         start_io_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         io_rvalid_q  <= 1'b0;
         cpu_rd_q     <= '0;
         io_rd_q      <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         burst_q      <= burst_d;
         start_io_q   <= start_io_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         io_rvalid_q  <= io_rvalid_d;
         cpu_rd_q     <= cpu_rd_d;
         io_rd_q      <= io_rd_d;
      end
   end

   assign cpu_gnt    = cpu_win;
   assign io_gnt     = io_win;
   assign mem_we     = win_we && !hit_flag;
   assign mem_a      = win_addr;
   assign mem_wd     = win_wd;
   assign cpu_rvalid = cpu_rvalid_q;
   assign io_rvalid  = io_rvalid_q;
   assign cpu_rd     = cpu_rd_q;
   assign io_rd      = io_rd_q;
   assign start_io   = start_io_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter; memory stand-in returns mem_a + 0x122F.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, io_req, io_we, io_burst;
   logic [31:0] cpu_addr, cpu_wd, io_addr, io_wd;
   logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_we, start_io;
   logic [31:0] cpu_rd, io_rd, mem_a, mem_wd, mem_rd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mem_rd = mem_a + 32'h0000_122F;

   data_mem_arbiter #(
      .WIDTH(32), .IO_ADDR(204), .STARVE_LIMIT(4), .BURST_MAX(8)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wd(io_wd),
      .io_burst(io_burst), .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rd(io_rd),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .start_io(start_io)
   );

   task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic ir, input logic iw, input logic [31:0] ia, input logic [31:0] idd,
                         input logic ib);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
      io_req = ir; io_we = iw; io_addr = ia; io_wd = idd; io_burst = ib;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
      // read issued during reset: grant is combinational but no rvalid follows
      set_in(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rst_gnt got=%0b want=1", cpu_gnt); end
      tick;
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%0b want=0", cpu_rvalid); end
      n_cmp++; if (cpu_rd !== 32'd0) begin n_err++; $display("FAIL rst_cpu_rd got=%0h want=0", cpu_rd); end
      n_cmp++; if (start_io !== 1'b0) begin n_err++; $display("FAIL rst_start got=%0b want=0", start_io); end
      n_cmp++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_io_rvalid got=%0b want=0", io_rvalid); end
      reset = 1'b0;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
   endtask

   task automatic test_idle;
      set_in(1'b0, 1'b0, 32'd77, 32'd9, 1'b0, 1'b0, 32'd88, 32'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if ({mem_we, cpu_gnt, io_gnt} !== 3'b000) begin n_err++; $display("FAIL idle_ctl cyc=%0d got=%b want=000", i, {mem_we, cpu_gnt, io_gnt}); end
         n_cmp++; if (mem_a !== 32'd0) begin n_err++; $display("FAIL idle_addr cyc=%0d got=%0h want=0", i, mem_a); end
         tick;
         n_cmp++; if ({cpu_rvalid, io_rvalid} !== 2'b00) begin n_err++; $display("FAIL idle_rvalid cyc=%0d got=%b want=00", i, {cpu_rvalid, io_rvalid}); end
      end
   endtask

   task automatic test_cpu_read;
      set_in(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if ({cpu_gnt, io_gnt, mem_we} !== 3'b100) begin n_err++; $display("FAIL crd_ctl got=%b want=100", {cpu_gnt, io_gnt, mem_we}); end
      n_cmp++; if (mem_a !== 32'd5) begin n_err++; $display("FAIL crd_addr got=%0h want=5", mem_a); end
      tick;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      n_cmp++; if ({cpu_rvalid, io_rvalid} !== 2'b10) begin n_err++; $display("FAIL crd_rvalid got=%b want=10", {cpu_rvalid, io_rvalid}); end
      n_cmp++; if (cpu_rd !== 32'h1234) begin n_err++; $display("FAIL crd_data got=%0h want=1234", cpu_rd); end
      tick;
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL crd_pulse got=%0b want=0", cpu_rvalid); end
      n_cmp++; if (cpu_rd !== 32'h1234) begin n_err++; $display("FAIL crd_hold got=%0h want=1234", cpu_rd); end
   endtask

   task automatic test_cpu_write;
      set_in(1'b1, 1'b1, 32'd20, 32'hDEAD, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if ({cpu_gnt, mem_we} !== 2'b11) begin n_err++; $display("FAIL cwr_ctl got=%b want=11", {cpu_gnt, mem_we}); end
      n_cmp++; if ({mem_a, mem_wd} !== {32'd20, 32'hDEAD}) begin n_err++; $display("FAIL cwr_bus got=%0h/%0h want=14/dead", mem_a, mem_wd); end
      tick;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL cwr_rvalid got=%0b want=0", cpu_rvalid); end
      tick;
   endtask

   task automatic test_contention;
      logic want_io;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b0, 32'(10 + i), 32'd0, 1'b1, 1'b0, 32'(50 + i), 32'd0, 1'b0);
         want_io = (i % 5 == 4);
         #1;
         n_cmp++; if ({cpu_gnt, io_gnt} !== {!want_io, want_io}) begin n_err++; $display("FAIL cont_gnt cyc=%0d got=%b want=%b", i, {cpu_gnt, io_gnt}, {!want_io, want_io}); end
         tick;
         n_cmp++; if (io_rvalid !== want_io) begin n_err++; $display("FAIL cont_iorv cyc=%0d got=%0b want=%0b", i, io_rvalid, want_io); end
         if (i == 4) begin
            n_cmp++; if (io_rd !== 32'h1265) begin n_err++; $display("FAIL cont_iord got=%0h want=1265", io_rd); end
         end
      end
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
   endtask

   task automatic test_burst_cap;
      logic        want_io;
      logic [31:0] want_a;
      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, 1'b0, 32'(300 + i), 32'd0, 1'b1, 1'b0, 32'(99 + i), 32'd0, 1'b1);
         want_io = ((i >= 4) && (i <= 11)) || (i == 16);
         want_a  = want_io ? 32'(99 + i) : 32'(300 + i);
         #1;
         n_cmp++; if ({cpu_gnt, io_gnt} !== {!want_io, want_io}) begin n_err++; $display("FAIL burst_gnt cyc=%0d got=%b want=%b", i, {cpu_gnt, io_gnt}, {!want_io, want_io}); end
         n_cmp++; if (mem_a !== want_a) begin n_err++; $display("FAIL burst_addr cyc=%0d got=%0d want=%0d", i, mem_a, want_a); end
         tick;
      end
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
      tick;
   endtask

   task automatic test_start_flag;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd204, 32'd1, 1'b0);
      #1;
      n_cmp++; if ({io_gnt, mem_we} !== 2'b10) begin n_err++; $display("FAIL flag_iowr got=%b want=10", {io_gnt, mem_we}); end
      tick;
      n_cmp++; if (start_io !== 1'b1) begin n_err++; $display("FAIL flag_set got=%0b want=1", start_io); end
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd204, 32'd0, 1'b0);
      tick;
      n_cmp++; if ({io_rvalid, io_rd} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL flag_iord got=%0b/%0h want=1/1", io_rvalid, io_rd); end
      set_in(1'b1, 1'b0, 32'd204, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
      n_cmp++; if ({cpu_rvalid, cpu_rd} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL flag_cpurd got=%0b/%0h want=1/1", cpu_rvalid, cpu_rd); end
      set_in(1'b1, 1'b1, 32'd204, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      n_cmp++; if ({cpu_gnt, mem_we} !== 2'b10) begin n_err++; $display("FAIL flag_cpuwr got=%b want=10", {cpu_gnt, mem_we}); end
      tick;
      n_cmp++; if (start_io !== 1'b0) begin n_err++; $display("FAIL flag_clr got=%0b want=0", start_io); end
      set_in(1'b1, 1'b0, 32'd204, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
      n_cmp++; if (cpu_rd !== 32'd0) begin n_err++; $display("FAIL flag_rd0 got=%0h want=0", cpu_rd); end
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
   endtask

   task automatic test_reset_midburst;
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd204, 32'd1, 1'b0);
      tick;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'(400 + i), 32'd0, 1'b1);
         tick;
      end
      // reset with the burst still owning the port and a read issued
      reset = 1'b1;
      set_in(1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 1'b0, 32'd403, 32'd0, 1'b1);
      #1;
      n_cmp++; if ({cpu_gnt, io_gnt} !== 2'b01) begin n_err++; $display("FAIL mrst_gnt got=%b want=01", {cpu_gnt, io_gnt}); end
      tick;
      reset = 1'b0;
      n_cmp++; if ({io_rvalid, start_io} !== 2'b00) begin n_err++; $display("FAIL mrst_regs got=%b want=00", {io_rvalid, start_io}); end
      n_cmp++; if (io_rd !== 32'd0) begin n_err++; $display("FAIL mrst_iord got=%0h want=0", io_rd); end
      #1;
      n_cmp++; if ({cpu_gnt, io_gnt} !== 2'b10) begin n_err++; $display("FAIL mrst_post got=%b want=10", {cpu_gnt, io_gnt}); end
      tick;
      n_cmp++; if ({cpu_rvalid, cpu_rd} !== {1'b1, 32'h1236}) begin n_err++; $display("FAIL mrst_cpurd got=%0b/%0h want=1/1236", cpu_rvalid, cpu_rd); end
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick;
   endtask

   initial begin
      test_reset;
      test_idle;
      test_cpu_read;
      test_cpu_write;
      test_contention;
      test_burst_cap;
      test_start_flag;
      test_reset_midburst;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
